// File: rtl/fb_pkg.sv
// Shared types and geometry helpers for the double-buffered framebuffer controller.
package fb_pkg;

   typedef enum logic [1:0] {
      START,
      RENDER,
      DONE,
      SWAP
   } fb_state_t;

   localparam int BANK_BITS  = 1;
   localparam int STAT_WIDTH = 16;

   function automatic int fb_depth(input int width, input int height);
      return width * height;
   endfunction

   localparam int FB_DEPTH = fb_depth(320, 180);

endpackage

// File: rtl/fb_frame_stats.sv
// Frame statistics: counts bank swaps and repeated (not-yet-rendered) frames.
// One-cycle update latency; counters wrap and never stall anything.
module fb_frame_stats
   import fb_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  swap_evt,
   input  logic                  repeat_evt,
   output logic [STAT_WIDTH-1:0] frames_rendered,
   output logic [STAT_WIDTH-1:0] frames_repeated
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frames_rendered <= '0;
         frames_repeated <= '0;
      end else begin
         if (swap_evt)
            frames_rendered <= frames_rendered + 1'b1;
         if (repeat_evt)
            frames_repeated <= frames_repeated + 1'b1;
      end
   end

endmodule

// File: rtl/framebuffer_swap_ctrl.sv
// Double-buffer swap controller: writes go to the back bank, reads to the front, swap only at vblank.
// Write/read paths are 1-cycle registered; no backpressure, illegal writes are dropped. Option: FB_STATS_EN.
module framebuffer_swap_ctrl
   import fb_pkg::*;
#(
   parameter int SCREEN_WIDTH  = 320,
   parameter int SCREEN_HEIGHT = 180,
   parameter int PIXEL_WIDTH   = 16,
   parameter int ADDR_WIDTH    = 16
) (
   input  logic                            pixel_clk_in,
   input  logic                            rst_in,
   input  logic                            ray_valid_in,
   input  logic [ADDR_WIDTH-1:0]           ray_address_in,
   input  logic [PIXEL_WIDTH-1:0]          ray_pixel_in,
   input  logic                            ray_last_pixel_in,
   input  logic                            new_frame_in,
   input  logic [ADDR_WIDTH-1:0]           video_addr_in,
   output logic                            wr_en_out,
   output logic [ADDR_WIDTH+BANK_BITS-1:0] wr_addr_out,
   output logic [PIXEL_WIDTH-1:0]          wr_data_out,
   output logic [ADDR_WIDTH+BANK_BITS-1:0] rd_addr_out,
   output logic                            front_sel_out,
   output logic                            frame_start_out,
   output logic                            wr_err_out
`ifdef FB_STATS_EN
   ,
   output logic [STAT_WIDTH-1:0]           frames_rendered_out,
   output logic [STAT_WIDTH-1:0]           frames_repeated_out
`endif
);

   localparam logic [ADDR_WIDTH-1:0] DEPTH = ADDR_WIDTH'(fb_depth(SCREEN_WIDTH, SCREEN_HEIGHT));

   fb_state_t state;
   fb_state_t state_nxt;

   logic in_render;
   logic last_wr;
   logic wr_ok;

   assign in_render = (state == RENDER);
   assign last_wr   = ray_valid_in & ray_last_pixel_in;
   assign wr_ok     = ray_valid_in & in_render & (ray_address_in < DEPTH);

   always_ff @(posedge pixel_clk_in or negedge rst_in) begin
      if (!rst_in)
         state <= START;
      else
         state <= state_nxt;
   end

   // A vblank without a finished frame simply repeats the current front bank.
   always_comb begin
      state_nxt = state;
      case (state)
         START:   state_nxt = RENDER;
         RENDER:  if (last_wr) state_nxt = new_frame_in ? SWAP : DONE;
         DONE:    if (new_frame_in) state_nxt = SWAP;
         SWAP:    state_nxt = START;
         default: state_nxt = START;
      endcase
   end

   always_ff @(posedge pixel_clk_in or negedge rst_in) begin
      if (!rst_in) begin
         wr_en_out       <= 1'b0;
         wr_addr_out     <= '0;
         wr_data_out     <= '0;
         rd_addr_out     <= '0;
         front_sel_out   <= 1'b0;
         frame_start_out <= 1'b0;
         wr_err_out      <= 1'b0;
      end else begin
         wr_en_out <= wr_ok;
         if (ray_valid_in) begin
            wr_addr_out <= {~front_sel_out, ray_address_in};
            wr_data_out <= ray_pixel_in;
         end
         rd_addr_out     <= {front_sel_out, video_addr_in};
         frame_start_out <= (state == START);
         if (state == SWAP)
            front_sel_out <= ~front_sel_out;
         if (ray_valid_in && !wr_ok)
            wr_err_out <= 1'b1;
      end
   end

`ifdef FB_STATS_EN
   logic swap_evt;
   logic repeat_evt;

   assign swap_evt   = (state == SWAP);
   assign repeat_evt = in_render & new_frame_in & ~last_wr;

   fb_frame_stats u_stats (
      .clk             (pixel_clk_in),
      .rst_n           (rst_in),
      .swap_evt        (swap_evt),
      .repeat_evt      (repeat_evt),
      .frames_rendered (frames_rendered_out),
      .frames_repeated (frames_repeated_out)
   );
`else
   // Statistics disabled: no counters are built.
`endif

endmodule
